// File: rtl/regfile_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths, constants and types for the register-file
//                write-port controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // One pending register-file write (address + data)
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_ctrl_if
//  Description : Producer request channels and register-file write port of
//                the write controller. master = producers/observer side,
//                slave = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_ctrl_if
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) ();

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  a_valid;
   logic [REG_ADDR_W-1:0] a_addr;
   logic [REG_DATA_W-1:0] a_data;
   logic                  a_ready;
   logic                  b_valid;
   logic [REG_ADDR_W-1:0] b_addr;
   logic [REG_DATA_W-1:0] b_data;
   logic                  b_ready;
   logic                  RegWrite;
   logic [REG_ADDR_W-1:0] WriteRegister;
   logic [REG_DATA_W-1:0] WriteData;
   logic                  init_done;
   logic [CNT_W-1:0]      fifo_count;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready, RegWrite, WriteRegister, WriteData,
             init_done, fifo_count
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready, RegWrite, WriteRegister, WriteData,
             init_done, fifo_count
   );

endinterface
`default_nettype wire

// File: rtl/regfile_write_ctrl_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous FIFO for secondary writebacks. Pointers wrap
//                modulo DEPTH (power of two); the occupancy count tells full
//                from empty. Storage is not reset: only entries covered by
//                the count are ever read.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             w_do_push;
   logic             w_do_pop;

   // Guard against overflow/underflow even if the caller misbehaves
   assign w_do_pop  = pop_i  && (count_q != '0);
   assign w_do_push = push_i && (count_q != C_FULL);

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Entry storage: write at the tail on push
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Pointers and occupancy; simultaneous push+pop leaves the count unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_ctrl
//  Description : Owns the register-file write port. After reset it sweeps
//                zeros into all 32 registers, then arbitrates a priority
//                single-cycle source (A) against a FIFO-buffered multi-cycle
//                source (B) with a starvation guard, and suppresses the
//                write enable for architectural writes to $0.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_ctrl
   import regfile_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_write_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SW_W  = $clog2(STARVE_LIMIT + 1);

   localparam logic [0:0] ST_INIT = INIT;
   localparam logic [0:0] ST_RUN  = RUN;

   localparam logic [CNT_W-1:0]      C_DEPTH    = CNT_W'(DEPTH);
   localparam logic [SW_W-1:0]       C_STARVE   = SW_W'(STARVE_LIMIT);
   localparam logic [REG_ADDR_W-1:0] C_LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

   logic [0:0]            state_q,     state_d;
   logic [REG_ADDR_W-1:0] sweep_q,     sweep_d;
   logic [SW_W-1:0]       starve_q,    starve_d;
   logic                  we_q,        we_d;
   logic [REG_ADDR_W-1:0] waddr_q,     waddr_d;
   logic [REG_DATA_W-1:0] wdata_q,     wdata_d;
   logic                  init_done_q, init_done_d;

   logic [CNT_W-1:0] w_count;
   logic             w_nonempty;
   logic             w_force;
   logic             w_b_ready;
   logic             w_issue_a;
   logic             w_issue_b;
   wb_req_t          w_b_req;
   wb_req_t          w_head;

   assign w_b_req.addr = bus.b_addr;
   assign w_b_req.data = bus.b_data;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(wb_req_t))
   ) u_wb_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (bus.b_valid && w_b_ready),
      .din_i   (w_b_req),
      .pop_i   (w_issue_b),
      .head_o  (w_head),
      .count_o (w_count)
   );

   // Readiness uses registered occupancy: no accept while full, even if popping
   assign w_nonempty = (w_count != '0);
   assign w_force    = (starve_q == C_STARVE) && w_nonempty;
   assign w_b_ready  = (state_q == ST_RUN) && (w_count < C_DEPTH);

   assign bus.a_ready       = (state_q == ST_RUN) && !w_force;
   assign bus.b_ready       = w_b_ready;
   assign bus.RegWrite      = we_q;
   assign bus.WriteRegister = waddr_q;
   assign bus.WriteData     = wdata_q;
   assign bus.init_done     = init_done_q;
   assign bus.fifo_count    = w_count;

   // Issue select: forced B, then A, then any queued B
   always_comb begin
      w_issue_a = 1'b0;
      w_issue_b = 1'b0;
      if (state_q == ST_RUN) begin
         if (w_force)             w_issue_b = 1'b1;
         else if (bus.a_valid)    w_issue_a = 1'b1;
         else if (w_nonempty)     w_issue_b = 1'b1;
      end
   end

   // Next-state: zero sweep in INIT, arbitrated writeback with $0 filter in RUN
   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      starve_d    = starve_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      init_done_d = init_done_q;
      case (state_q)
         ST_INIT: begin
            we_d    = 1'b1;
            waddr_d = sweep_q;
            wdata_d = '0;
            sweep_d = sweep_q + REG_ADDR_W'(1);
            if (sweep_q == C_LAST_REG) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end
         end
         default: begin
            if (w_issue_a) begin
               we_d    = (bus.a_addr != ZERO_REG);
               waddr_d = bus.a_addr;
               wdata_d = bus.a_data;
            end else if (w_issue_b) begin
               we_d    = (w_head.addr != ZERO_REG);
               waddr_d = w_head.addr;
               wdata_d = w_head.data;
            end
            // Count A wins only while B is waiting; any B pop or empty FIFO resets it
            if (w_issue_b || !w_nonempty) begin
               starve_d = '0;
            end else if (w_issue_a && (starve_q != C_STARVE)) begin
               starve_d = starve_q + SW_W'(1);
            end
         end
      endcase
   end

   // State and registered write-port outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         sweep_q     <= '0;
         starve_q    <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         starve_q    <= starve_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         init_done_q <= init_done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_ctrl
//  Description : Self-checking bench for regfile_write_ctrl: reference model
//                with an expected-output queue, a vector table for RUN-mode
//                arbitration, and hand-written starvation/drain/reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_ctrl;
   import regfile_pkg::*;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   regfile_write_ctrl_if #(.DEPTH(DEPTH)) bus ();

   regfile_write_ctrl #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        done;
      int          cnt;
   } exp_t;

   typedef struct {
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  ba;
      logic [31:0] bd;
      logic        x_we;
      logic [4:0]  x_addr;
      logic [31:0] x_data;
      int          x_cnt;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   int          m_state;
   int          m_p;
   int          m_starve;
   logic        m_done;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   wb_req_t     m_q[$];
   exp_t        sb[$];
   bit          m_pop;
   bit          m_iss_a_ne;
   bit          m_b_acc;

   vec_t vt[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   // One clock: model predicts, expectation queued, edge, DUT compared
   task automatic cycle();
      exp_t    e;
      logic    ar, br, frc;
      int      cnt;
      wb_req_t w;
      bit      has_w;
      m_pop = 0; m_iss_a_ne = 0; m_b_acc = 0;
      has_w = 0; w = '0;
      e.we = 1'b0;
      if (reset) begin
         m_state = 0; m_p = 0; m_starve = 0; m_done = 1'b0;
         m_waddr = '0; m_wdata = '0;
         m_q.delete();
      end else if (m_state == 0) begin
         chk("init_a_ready", 32'(bus.a_ready), 32'd0);
         chk("init_b_ready", 32'(bus.b_ready), 32'd0);
         e.we = 1'b1; m_waddr = 5'(m_p); m_wdata = '0;
         if (m_p == 31) begin m_state = 1; m_done = 1'b1; end
         m_p++;
      end else begin
         cnt = m_q.size();
         frc = (m_starve == STARVE_LIMIT) && (cnt != 0);
         ar  = !frc;
         br  = (cnt < DEPTH);
         chk("a_ready", 32'(bus.a_ready), 32'(ar));
         chk("b_ready", 32'(bus.b_ready), 32'(br));
         if (frc || (!bus.a_valid && cnt != 0)) begin
            w = m_q.pop_front(); has_w = 1; m_starve = 0; m_pop = 1;
         end else if (bus.a_valid) begin
            w.addr = bus.a_addr; w.data = bus.a_data; has_w = 1;
            if (cnt != 0) begin
               m_iss_a_ne = 1;
               if (m_starve < STARVE_LIMIT) m_starve++;
            end else begin
               m_starve = 0;
            end
         end else begin
            m_starve = 0;
         end
         if (bus.b_valid && br) begin
            m_q.push_back('{addr: bus.b_addr, data: bus.b_data});
            m_b_acc = 1;
         end
         if (has_w) begin
            e.we = (w.addr != 5'd0); m_waddr = w.addr; m_wdata = w.data;
         end
      end
      e.addr = m_waddr; e.data = m_wdata; e.done = m_done; e.cnt = m_q.size();
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk("RegWrite",      32'(bus.RegWrite),      32'(e.we));
      chk("WriteRegister", 32'(bus.WriteRegister), 32'(e.addr));
      chk("WriteData",     bus.WriteData,          e.data);
      chk("init_done",     32'(bus.init_done),     32'(e.done));
      chk("fifo_count",    32'(bus.fifo_count),    32'(e.cnt));
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
      bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
   endtask

   task automatic sweep_check(input string tag);
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'd9, 32'hBAD0_0000, 1'b0, 5'd0, 32'd0);
         cycle();
         chk({tag, "_we"},   32'(bus.RegWrite),      32'd1);
         chk({tag, "_addr"}, 32'(bus.WriteRegister), 32'(i));
         chk({tag, "_data"}, bus.WriteData,          32'd0);
         chk({tag, "_done"}, 32'(bus.init_done),     (i == 31) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      int  b_idx, run, pops;
      bit  full_seen;

      //            av  aa     ad            bv  ba      bd        x_we x_addr  x_data        cnt
      vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'd0,    1'b1, 5'd5,  32'hDEADBEEF, 0};
      vt[1]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,    1'b0, 5'd5,  32'hDEADBEEF, 0};
      vt[2]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'd0,    1'b0, 5'd0,  32'h1234,     0};
      vt[3]  = '{1'b1, 5'd1,  32'hCAFE0001, 1'b0, 5'd0,  32'd0,    1'b1, 5'd1,  32'hCAFE0001, 0};
      vt[4]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd3,  32'h33,   1'b0, 5'd1,  32'hCAFE0001, 1};
      vt[5]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,    1'b1, 5'd3,  32'h33,       0};
      vt[6]  = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd4,  32'h44,   1'b1, 5'd2,  32'h22,       1};
      vt[7]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,    1'b1, 5'd4,  32'h44,       0};
      vt[8]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  32'h55,   1'b0, 5'd4,  32'h44,       1};
      vt[9]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,    1'b0, 5'd0,  32'h55,       0};
      vt[10] = '{1'b1, 5'd6,  32'h66,       1'b1, 5'd12, 32'hC,    1'b1, 5'd6,  32'h66,       1};
      vt[11] = '{1'b1, 5'd7,  32'h77,       1'b0, 5'd0,  32'd0,    1'b1, 5'd7,  32'h77,       1};
      vt[12] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,    1'b1, 5'd12, 32'hC,        0};

      // reset, then zero sweep with A requesting throughout
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      reset = 1'b1;
      cycle();
      cycle();
      chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
      chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
      reset = 1'b0;
      sweep_check("sweep");

      // RUN-mode arbitration table
      for (int i = 0; i < 13; i++) begin
         drive(vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd);
         cycle();
         chk($sformatf("vec%0d_we", i),   32'(bus.RegWrite),      32'(vt[i].x_we));
         chk($sformatf("vec%0d_addr", i), 32'(bus.WriteRegister), 32'(vt[i].x_addr));
         chk($sformatf("vec%0d_data", i), bus.WriteData,          vt[i].x_data);
         chk($sformatf("vec%0d_cnt", i),  32'(bus.fifo_count),    32'(vt[i].x_cnt));
      end

      // A held busy, B 7..11 pushed: FIFO fills, then forced B every 8 A issues
      b_idx = 0; run = 0; pops = 0; full_seen = 0;
      for (int c = 0; c < 60 && pops < 2; c++) begin
         drive(1'b1, 5'(16 + (c % 8)), 32'hA000_0000 | 32'(c),
               (b_idx < 5), 5'(7 + b_idx), 32'(7 + b_idx));
         if (b_idx == 4 && !full_seen) begin
            chk("full_count",   32'(bus.fifo_count), 32'd4);
            chk("full_b_ready", 32'(bus.b_ready),    32'd0);
            full_seen = 1;
         end
         cycle();
         if (m_b_acc) b_idx++;
         if (m_iss_a_ne) run++;
         if (m_pop) begin
            chk("forced_run",  32'(run),               32'd8);
            chk("forced_we",   32'(bus.RegWrite),      32'd1);
            chk("forced_addr", 32'(bus.WriteRegister), 32'(7 + pops));
            chk("forced_data", bus.WriteData,          32'(7 + pops));
            pops++;
            run = 0;
         end
      end
      chk("forced_pops", 32'(pops),      32'd2);
      chk("full_seen",   32'(full_seen), 32'd1);

      // release A: remaining B entries drain back-to-back in order
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         cycle();
         chk("drain_we",   32'(bus.RegWrite),      32'd1);
         chk("drain_addr", 32'(bus.WriteRegister), 32'(9 + k));
         chk("drain_data", bus.WriteData,          32'(9 + k));
      end
      chk("drain_empty", 32'(bus.fifo_count), 32'd0);

      // mid-run reset with two queued B entries
      drive(1'b1, 5'd20, 32'h2020, 1'b1, 5'd13, 32'hD13);
      cycle();
      drive(1'b1, 5'd21, 32'h2121, 1'b1, 5'd14, 32'hD14);
      cycle();
      chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("mrst_we",      32'(bus.RegWrite),      32'd0);
      chk("mrst_addr",    32'(bus.WriteRegister), 32'd0);
      chk("mrst_data",    bus.WriteData,          32'd0);
      chk("mrst_done",    32'(bus.init_done),     32'd0);
      chk("mrst_count",   32'(bus.fifo_count),    32'd0);
      chk("mrst_a_ready", 32'(bus.a_ready),       32'd0);
      chk("mrst_b_ready", 32'(bus.b_ready),       32'd0);
      sweep_check("resweep");
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         cycle();
         chk("no_stale_we", 32'(bus.RegWrite), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
